fpu_issue_ctrl: RTL and testbench



---
 rtl/fpu_pkg.sv | 24 ++
 rtl/fpu_flag_decode.sv | 22 ++
 rtl/fpu_issue_ctrl.sv | 114 +++++++++++
 tb/tb_fpu_issue_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue controller: FSM encoding,
// IEEE-754 single-precision field positions and status flag indices.
// Imported by fpu_issue_ctrl and fpu_flag_decode.
package fpu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam int SIGN_BIT = 31;
   localparam int EXP_MSB  = 30;
   localparam int EXP_LSB  = 23;
   localparam int MANT_W   = 23;
   localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

   localparam int FLAGS_W   = 4;
   localparam int FLAG_NAN  = 3;
   localparam int FLAG_INF  = 2;
   localparam int FLAG_ZERO = 1;
   localparam int FLAG_SIGN = 0;

endpackage

// File: rtl/fpu_flag_decode.sv
// Combinational IEEE-754 single-precision classifier: {nan, inf, zero, sign}.
// Zero latency; no handshake (pure function of its input).
// Denormals are reported as non-zero; only +/-0 sets the zero flag.
module fpu_flag_decode
   import fpu_pkg::*;
(
   input  logic [31:0]        value,
   output logic [FLAGS_W-1:0] flags
);

   logic [7:0]        exp_f;
   logic [MANT_W-1:0] mant_f;

   assign exp_f  = value[EXP_MSB:EXP_LSB];
   assign mant_f = value[MANT_W-1:0];

   assign flags[FLAG_NAN]  = (exp_f == EXP_ALL_ONES) && (mant_f != '0);
   assign flags[FLAG_INF]  = (exp_f == EXP_ALL_ONES) && (mant_f == '0);
   assign flags[FLAG_ZERO] = (exp_f == 8'h00) && (mant_f == '0);
   assign flags[FLAG_SIGN] = value[SIGN_BIT];

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Sequential front-end for a combinational FPU adder: registers operands,
// waits SETTLE_CYCLES (min 1) for the FPU path, captures the result.
// Latency: accept -> out_valid after SETTLE_CYCLES edges; result held under
// backpressure, new accept allowed in the release cycle. Macro FPU_FLAGS_EN
// adds a registered flags[3:0] = {nan, inf, zero, sign} output.
module fpu_issue_ctrl
   import fpu_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 16
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       op_a,
   input  logic [31:0]       op_b,
   output logic [31:0]       fpu_a,
   output logic [31:0]       fpu_b,
   input  logic [31:0]       fpu_result,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       result,
`ifdef FPU_FLAGS_EN
   output logic [FLAGS_W-1:0] flags,
`endif
   output logic              busy,
   output logic [CNT_W-1:0]  ops_done
);

   // Settle time below one cycle is meaningless; clamp it.
   localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
   localparam int CW_RAW     = $clog2(SETTLE_EFF + 1);
   localparam int CW         = (CW_RAW < 1) ? 1 : CW_RAW;
   localparam logic [CW-1:0] RELOAD = CW'(SETTLE_EFF - 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic          accept;
   logic          rel;

`ifdef FPU_FLAGS_EN
   logic [FLAGS_W-1:0] flags_dec;

   fpu_flag_decode u_flag_decode (
      .value (fpu_result),
      .flags (flags_dec)
   );
`endif

   // Ready in IDLE, or in DONE when the held result leaves this same cycle.
   assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
   assign accept   = in_valid && in_ready;
   assign rel      = out_valid && out_ready;
   assign busy     = (state != IDLE);

   // Issue FSM: operand registers, settle counter, result capture, counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         fpu_a     <= '0;
         fpu_b     <= '0;
         result    <= '0;
         out_valid <= 1'b0;
         ops_done  <= '0;
`ifdef FPU_FLAGS_EN
         flags     <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  fpu_a <= op_a;
                  fpu_b <= op_b;
                  cnt   <= RELOAD;
                  state <= SETTLE;
               end
            end
            SETTLE: begin
               if (cnt == '0) begin
                  result    <= fpu_result;
`ifdef FPU_FLAGS_EN
                  flags     <= flags_dec;
`endif
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               if (rel) begin
                  out_valid <= 1'b0;
                  ops_done  <= ops_done + 1'b1;
                  if (accept) begin
                     fpu_a <= op_a;
                     fpu_b <= op_b;
                     cnt   <= RELOAD;
                     state <= SETTLE;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl with SETTLE_CYCLES=1 and SETTLE_CYCLES=4
// instances; the FPU is a lookup table of hand-computed IEEE-754 sums.
// The second instance uses a 2-bit ops_done so counter wrap is reachable.
module tb_fpu_issue_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   // Known sums only; anything else yields a quiet NaN so stray sampling shows.
   function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         64'h3FC00000_40500000: return 32'h40980000;  // 1.5 + 3.25
         64'hC0500000_40500000: return 32'h00000000;  // -3.25 + 3.25
         64'h42300000_43A40000: return 32'h43BA0000;  // 44 + 328
         64'hC3A40000_42300000: return 32'hC38E0000;  // -328 + 44
         default:               return 32'h7FC00000;
      endcase
   endfunction

   // Instance 1: SETTLE_CYCLES=1, 16-bit counter
   logic        in_valid1, in_ready1, out_valid1, out_ready1, busy1;
   logic [31:0] op_a1, op_b1, fpu_a1, fpu_b1, fpu_result1, result1;
   logic [15:0] ops_done1;
   // Instance 4: SETTLE_CYCLES=4, 2-bit counter
   logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4;
   logic [31:0] op_a4, op_b4, fpu_a4, fpu_b4, fpu_result4, result4;
   logic [1:0]  ops_done4;
`ifdef FPU_FLAGS_EN
   logic [3:0]  flags1, flags4;
`endif

   assign fpu_result1 = fpu_model(fpu_a1, fpu_b1);
   assign fpu_result4 = fpu_model(fpu_a4, fpu_b4);

   fpu_issue_ctrl #(.SETTLE_CYCLES(1), .CNT_W(16)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid1), .in_ready(in_ready1),
      .op_a(op_a1), .op_b(op_b1),
      .fpu_a(fpu_a1), .fpu_b(fpu_b1), .fpu_result(fpu_result1),
      .out_valid(out_valid1), .out_ready(out_ready1), .result(result1),
`ifdef FPU_FLAGS_EN
      .flags(flags1),
`endif
      .busy(busy1), .ops_done(ops_done1)
   );

   fpu_issue_ctrl #(.SETTLE_CYCLES(4), .CNT_W(2)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid4), .in_ready(in_ready4),
      .op_a(op_a4), .op_b(op_b4),
      .fpu_a(fpu_a4), .fpu_b(fpu_b4), .fpu_result(fpu_result4),
      .out_valid(out_valid4), .out_ready(out_ready4), .result(result4),
`ifdef FPU_FLAGS_EN
      .flags(flags4),
`endif
      .busy(busy4), .ops_done(ops_done4)
   );

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid1 = 0; out_ready1 = 0; op_a1 = '0; op_b1 = '0;
      in_valid4 = 0; out_ready4 = 0; op_a4 = '0; op_b4 = '0;
      #2;
      checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid1); end
      checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy1); end
      checks++; if (ops_done1 !== 16'h0) begin errors++; $display("FAIL reset_ops_done: got %h want 0000", ops_done1); end
      checks++; if (fpu_a1 !== 32'h0 || fpu_b1 !== 32'h0) begin errors++; $display("FAIL reset_fpu_ab: got %h/%h want 0/0", fpu_a1, fpu_b1); end
      checks++; if (result1 !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result1); end
`ifdef FPU_FLAGS_EN
      checks++; if (flags1 !== 4'h0) begin errors++; $display("FAIL reset_flags: got %b want 0000", flags1); end
`endif
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      checks++; if (in_ready1 !== 1'b1 || in_ready4 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b/%b want 1/1", in_ready1, in_ready4); end
   endtask

   task automatic test_basic();
      out_ready1 = 1; in_valid1 = 1; op_a1 = 32'h3FC00000; op_b1 = 32'h40500000;
      #1;
      checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL basic_in_ready: got %b want 1", in_ready1); end
      tick();
      in_valid1 = 0; op_a1 = 32'hFFFFFFFF;
      checks++; if (busy1 !== 1'b1 || out_valid1 !== 1'b0) begin errors++; $display("FAIL basic_settle: busy=%b out_valid=%b want 1/0", busy1, out_valid1); end
      checks++; if (fpu_a1 !== 32'h3FC00000 || fpu_b1 !== 32'h40500000) begin errors++; $display("FAIL basic_fpu_ab: got %h/%h want 3FC00000/40500000", fpu_a1, fpu_b1); end
      tick();
      checks++; if (out_valid1 !== 1'b1 || result1 !== 32'h40980000) begin errors++; $display("FAIL basic_result: valid=%b result=%h want 1/40980000", out_valid1, result1); end
      checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL basic_done_in_ready: got %b want 1", in_ready1); end
      tick();
      checks++; if (out_valid1 !== 1'b0 || busy1 !== 1'b0 || ops_done1 !== 16'd1) begin errors++; $display("FAIL basic_release: valid=%b busy=%b ops=%0d want 0/0/1", out_valid1, busy1, ops_done1); end
   endtask

   task automatic test_zero();
      in_valid1 = 1; op_a1 = 32'hC0500000; op_b1 = 32'h40500000;
      tick();
      in_valid1 = 0;
      tick();
      checks++; if (out_valid1 !== 1'b1 || result1 !== 32'h00000000) begin errors++; $display("FAIL zero_result: valid=%b result=%h want 1/00000000", out_valid1, result1); end
`ifdef FPU_FLAGS_EN
      checks++; if (flags1 !== 4'b0010) begin errors++; $display("FAIL zero_flags: got %b want 0010", flags1); end
`endif
      tick();
      checks++; if (ops_done1 !== 16'd2) begin errors++; $display("FAIL zero_ops_done: got %0d want 2", ops_done1); end
   endtask

   task automatic test_backpressure();
      out_ready1 = 0; in_valid1 = 1; op_a1 = 32'h42300000; op_b1 = 32'h43A40000;
      tick();
      in_valid1 = 0;
      tick();
      checks++; if (out_valid1 !== 1'b1 || result1 !== 32'h43BA0000) begin errors++; $display("FAIL bp_result: valid=%b result=%h want 1/43BA0000", out_valid1, result1); end
      in_valid1 = 1; op_a1 = 32'hC3A40000; op_b1 = 32'h42300000;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (out_valid1 !== 1'b1 || result1 !== 32'h43BA0000 || in_ready1 !== 1'b0 || fpu_a1 !== 32'h42300000) begin
            errors++;
            $display("FAIL bp_hold[%0d]: valid=%b result=%h in_ready=%b fpu_a=%h want 1/43BA0000/0/42300000", i, out_valid1, result1, in_ready1, fpu_a1);
         end
         tick();
      end
      checks++; if (ops_done1 !== 16'd2) begin errors++; $display("FAIL bp_ops_done: got %0d want 2", ops_done1); end
   endtask

   task automatic test_back_to_back();
      out_ready1 = 1;
      #1;
      checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b want 1", in_ready1); end
      tick();
      checks++; if (out_valid1 !== 1'b0 || busy1 !== 1'b1 || ops_done1 !== 16'd3) begin errors++; $display("FAIL b2b_accept: valid=%b busy=%b ops=%0d want 0/1/3", out_valid1, busy1, ops_done1); end
      checks++; if (fpu_a1 !== 32'hC3A40000 || fpu_b1 !== 32'h42300000) begin errors++; $display("FAIL b2b_fpu_ab: got %h/%h want C3A40000/42300000", fpu_a1, fpu_b1); end
      op_a1 = 32'h3FC00000; op_b1 = 32'h40500000;
      tick();
      checks++; if (out_valid1 !== 1'b1 || result1 !== 32'hC38E0000) begin errors++; $display("FAIL b2b_result: valid=%b result=%h want 1/C38E0000", out_valid1, result1); end
      tick();
      in_valid1 = 0;
      checks++; if (busy1 !== 1'b1 || ops_done1 !== 16'd4 || fpu_a1 !== 32'h3FC00000) begin errors++; $display("FAIL b2b_second: busy=%b ops=%0d fpu_a=%h want 1/4/3FC00000", busy1, ops_done1, fpu_a1); end
      tick();
      checks++; if (out_valid1 !== 1'b1 || result1 !== 32'h40980000) begin errors++; $display("FAIL b2b_result2: valid=%b result=%h want 1/40980000", out_valid1, result1); end
      tick();
      checks++; if (busy1 !== 1'b0 || ops_done1 !== 16'd5) begin errors++; $display("FAIL b2b_idle: busy=%b ops=%0d want 0/5", busy1, ops_done1); end
   endtask

   task automatic test_settle4();
      out_ready4 = 1; in_valid4 = 1; op_a4 = 32'h3FC00000; op_b4 = 32'h40500000;
      tick();
      in_valid4 = 0; op_a4 = 32'h12345678; op_b4 = 32'h9ABCDEF0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_valid4 !== 1'b0 || busy4 !== 1'b1 || fpu_a4 !== 32'h3FC00000 || fpu_b4 !== 32'h40500000) begin
            errors++;
            $display("FAIL settle4_wait[%0d]: valid=%b busy=%b fpu=%h/%h want 0/1/3FC00000/40500000", i, out_valid4, busy4, fpu_a4, fpu_b4);
         end
         tick();
      end
      checks++; if (out_valid4 !== 1'b1 || result4 !== 32'h40980000) begin errors++; $display("FAIL settle4_result: valid=%b result=%h want 1/40980000", out_valid4, result4); end
      tick();
      checks++; if (out_valid4 !== 1'b0 || ops_done4 !== 2'd1) begin errors++; $display("FAIL settle4_release: valid=%b ops=%0d want 0/1", out_valid4, ops_done4); end
   endtask

   task automatic test_reset_abort();
      logic saw_valid;
      in_valid4 = 1; op_a4 = 32'h42300000; op_b4 = 32'h43A40000;
      tick();
      in_valid4 = 0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (busy4 !== 1'b0 || out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin errors++; $display("FAIL abort_ctrl: busy=%b valid=%b in_ready=%b want 0/0/1", busy4, out_valid4, in_ready4); end
      checks++; if (fpu_a4 !== 32'h0 || fpu_b4 !== 32'h0 || result4 !== 32'h0) begin errors++; $display("FAIL abort_data: fpu=%h/%h result=%h want 0/0/0", fpu_a4, fpu_b4, result4); end
      checks++; if (ops_done4 !== 2'd0 || ops_done1 !== 16'd0) begin errors++; $display("FAIL abort_ops_done: got %0d/%0d want 0/0", ops_done4, ops_done1); end
      tick();
      rst_n = 1'b1;
      saw_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (out_valid4 !== 1'b0) saw_valid = 1'b1;
      end
      checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL abort_stale_valid: got %b want 0", saw_valid); end
   endtask

   task automatic test_wrap();
      logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      out_ready4 = 1; op_a4 = 32'h3FC00000; op_b4 = 32'h40500000;
      for (int n = 0; n < 5; n++) begin
         in_valid4 = 1;
         tick();
         in_valid4 = 0;
         for (int w = 0; w < 10 && out_valid4 !== 1'b1; w++) tick();
         checks++; if (out_valid4 !== 1'b1) begin errors++; $display("FAIL wrap_timeout[%0d]: out_valid=%b want 1", n, out_valid4); end
         tick();
         checks++; if (ops_done4 !== exp_cnt[n]) begin errors++; $display("FAIL wrap_count[%0d]: got %0d want %0d", n, ops_done4, exp_cnt[n]); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero();
      test_backpressure();
      test_back_to_back();
      test_settle4();
      test_reset_abort();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
